// File: rtl/conv1.sv
// conv1 - first convolution layer of the handwritten-digit datapath.
// Applies one 5x5 signed Q1.7 filter plus bias to a 28x28 image (valid
// padding, stride 1) and produces a 24x24 map, one output pixel per clock.
// Optional build macro CONV1_RELU_EN: clamp negative results to zero.
module conv1 (
  input  logic          clk,
  input  logic          iRst_n,
  input  logic          ena,
  input  logic [6271:0] tensor_in,
  input  logic [199:0]  filter_in,
  input  logic [7:0]    bias_in,
  output logic [4607:0] tensor_out,
  output logic          overflow,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t r_state;
  state_t w_nextState;

  logic [4:0]    r_row;
  logic [4:0]    r_col;
  logic [4607:0] r_tensor_out;
  logic          r_overflow;

  logic              w_start;
  logic              w_write;
  logic              w_last;
  logic signed [7:0]  w_pix;
  logic signed [7:0]  w_tap;
  logic signed [15:0] w_prod;
  logic signed [23:0] w_acc;
  logic signed [23:0] w_res;
  logic [7:0]         w_satByte;
  logic [7:0]         w_final;
  logic               w_sat;
  int                 w_inIdx;
  int                 w_outIdx;

  // Window MAC for the current (row,col): 25 products, bias, shift, saturate
  always_comb begin
    w_acc   = {{9{bias_in[7]}}, bias_in, 7'b0};
    w_pix   = '0;
    w_tap   = '0;
    w_prod  = '0;
    w_inIdx = 0;
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 5; j++) begin
        w_inIdx = ((int'(r_row) + i) * 28 + int'(r_col) + j) * 8;
        w_pix   = tensor_in[w_inIdx +: 8];
        w_tap   = filter_in[(i * 5 + j) * 8 +: 8];
        w_prod  = w_pix * w_tap;
        w_acc   = w_acc + {{8{w_prod[15]}}, w_prod};
      end
    end
    w_res     = w_acc >>> 7;
    w_sat     = 1'b0;
    w_satByte = w_res[7:0];
    if (w_res > 24'sd127) begin
      w_satByte = 8'h7F;
      w_sat     = 1'b1;
    end else if (w_res < -24'sd128) begin
      w_satByte = 8'h80;
      w_sat     = 1'b1;
    end
`ifdef CONV1_RELU_EN
    w_final = w_satByte[7] ? 8'h00 : w_satByte;
`else
    w_final = w_satByte;
`endif
    w_outIdx = (int'(r_row) * 24 + int'(r_col)) * 8;
  end

  // State register
  always_ff @(posedge clk or negedge iRst_n) begin
    if (!iRst_n) r_state <= IDLE;
    else         r_state <= w_nextState;
  end

  // Next-state and control strobes
  always_comb begin
    w_nextState = r_state;
    w_start     = 1'b0;
    w_write     = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (ena) begin
          w_nextState = RUN;
          w_start     = 1'b1;
        end
      end
      RUN: begin
        if (ena) begin
          w_write = 1'b1;
          if (r_row == 5'd23 && r_col == 5'd23) begin
            w_last      = 1'b1;
            w_nextState = DONE;
          end
        end
      end
      DONE: begin
        if (!ena) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Raster-order row/col counters; wrap to 0 after the last pixel
  always_ff @(posedge clk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_start || (w_write && w_last)) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_write) begin
      if (r_col == 5'd23) begin
        r_col <= '0;
        r_row <= r_row + 5'd1;
      end else begin
        r_col <= r_col + 5'd1;
      end
    end
  end

  // Output map and sticky overflow; overflow clears at the start of a run
  always_ff @(posedge clk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_tensor_out <= '0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_start) r_overflow <= 1'b0;
      if (w_write) begin
        r_tensor_out[w_outIdx +: 8] <= w_final;
        if (w_sat) r_overflow <= 1'b1;
      end
    end
  end

  assign tensor_out = r_tensor_out;
  assign overflow   = r_overflow;
  assign done       = (r_state == DONE);

endmodule

// File: tb/tb_conv1.sv
// Directed self-checking bench for conv1: uniform, saturation, negative,
// packing corners, pause and mid-run reset scenarios.
module tb_conv1;

  logic          clk;
  logic          rstN;
  logic          ena;
  logic [6271:0] tensorIn;
  logic [199:0]  filterIn;
  logic [7:0]    biasIn;
  logic [4607:0] tensorOut;
  logic          overflow;
  logic          done;

  int checkCount = 0;
  int errorCount = 0;
  int edges;
  int pauseEdges;
  logic [7:0] negExpected;

  conv1 dut (
    .clk        (clk),
    .iRst_n     (rstN),
    .ena        (ena),
    .tensor_in  (tensorIn),
    .filter_in  (filterIn),
    .bias_in    (biasIn),
    .tensor_out (tensorOut),
    .overflow   (overflow),
    .done       (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] pix, input logic [7:0] tap,
                               input logic [7:0] bias);
    for (int k = 0; k < 784; k++) tensorIn[k*8 +: 8] = pix;
    for (int k = 0; k < 25; k++)  filterIn[k*8 +: 8] = tap;
    biasIn = bias;
  endtask

  function automatic int countByte(input logic [4607:0] v, input logic [7:0] b);
    int n = 0;
    for (int k = 0; k < 576; k++) if (v[k*8 +: 8] == b) n++;
    return n;
  endfunction

  task automatic stepEdges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic runUntilDone(output int count);
    count = 0;
    while (!done && count < 2000) begin
      @(posedge clk);
      #1;
      count++;
    end
  endtask

  task automatic goIdle(input string tag);
    ena = 1'b0;
    stepEdges(1);
    checkOutput(tag, 32'(done), 32'd0);
  endtask

  initial begin
    rstN = 1'b0;
    ena  = 1'b0;
    applyStimulus(8'h22, 8'h07, 8'h0B);
    #3;
    checkOutput("reset_out_zero", 32'(countByte(tensorOut, 8'h00)), 32'd576);
    checkOutput("reset_overflow", 32'(overflow), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    #10 rstN = 1'b1;

    // Uniform, no overflow
    ena = 1'b1;
    runUntilDone(edges);
    checkOutput("uniform_latency", 32'(edges), 32'd577);
    checkOutput("uniform_bytes", 32'(countByte(tensorOut, 8'h39)), 32'd576);
    checkOutput("uniform_overflow", 32'(overflow), 32'd0);
    stepEdges(3);
    checkOutput("done_held_ena_high", 32'(done), 32'd1);
    goIdle("uniform_idle_done");
    checkOutput("idle_out_hold", 32'(countByte(tensorOut, 8'h39)), 32'd576);

    // Positive saturation
    applyStimulus(8'h22, 8'h47, 8'h0B);
    ena = 1'b1;
    runUntilDone(edges);
    checkOutput("pos_latency", 32'(edges), 32'd577);
    checkOutput("pos_bytes", 32'(countByte(tensorOut, 8'h7F)), 32'd576);
    checkOutput("pos_overflow", 32'(overflow), 32'd1);
    checkOutput("pos_done", 32'(done), 32'd1);
    goIdle("pos_idle_done");
    checkOutput("idle_overflow_hold", 32'(overflow), 32'd1);

    // Negative values (floor truncation); overflow must clear on start
`ifdef CONV1_RELU_EN
    negExpected = 8'h00;
`else
    negExpected = 8'hD1;
`endif
    applyStimulus(8'h22, 8'hF9, 8'h00);
    ena = 1'b1;
    stepEdges(1);
    checkOutput("start_clears_overflow", 32'(overflow), 32'd0);
    runUntilDone(edges);
    checkOutput("neg_latency", 32'(edges), 32'd576);
    checkOutput("neg_bytes", 32'(countByte(tensorOut, negExpected)), 32'd576);
    checkOutput("neg_overflow", 32'(overflow), 32'd0);
    goIdle("neg_idle_done");

    // Packing / corners
    tensorIn = '0;
    tensorIn[7:0] = 8'h7F;
    tensorIn[(27*28+27)*8 +: 8] = 8'h40;
    filterIn = '0;
    filterIn[7:0] = 8'h7F;
    filterIn[24*8 +: 8] = 8'h40;
    biasIn = 8'h00;
    ena = 1'b1;
    runUntilDone(edges);
    checkOutput("corner_latency", 32'(edges), 32'd577);
    checkOutput("corner_00", 32'(tensorOut[7:0]), 32'h7E);
    checkOutput("corner_2323", 32'(tensorOut[575*8 +: 8]), 32'h20);
    checkOutput("corner_zeros", 32'(countByte(tensorOut, 8'h00)), 32'd574);
    checkOutput("corner_overflow", 32'(overflow), 32'd0);
    goIdle("corner_idle_done");

    // Pause mid-run for 10 edges
    applyStimulus(8'h22, 8'h07, 8'h0B);
    ena = 1'b1;
    stepEdges(201);
    checkOutput("pause_pre_count", 32'(countByte(tensorOut, 8'h39)), 32'd200);
    ena = 1'b0;
    stepEdges(10);
    checkOutput("pause_no_writes", 32'(countByte(tensorOut, 8'h39)), 32'd200);
    checkOutput("pause_done_low", 32'(done), 32'd0);
    ena = 1'b1;
    runUntilDone(pauseEdges);
    checkOutput("pause_latency", 32'(201 + 10 + pauseEdges), 32'd587);
    checkOutput("pause_bytes", 32'(countByte(tensorOut, 8'h39)), 32'd576);
    goIdle("pause_idle_done");

    // Reset mid-run
    applyStimulus(8'h22, 8'h47, 8'h0B);
    ena = 1'b1;
    stepEdges(100);
    checkOutput("prereset_overflow", 32'(overflow), 32'd1);
    #2 rstN = 1'b0;
    #1;
    checkOutput("midreset_out_zero", 32'(countByte(tensorOut, 8'h00)), 32'd576);
    checkOutput("midreset_overflow", 32'(overflow), 32'd0);
    checkOutput("midreset_done", 32'(done), 32'd0);
    applyStimulus(8'h22, 8'h07, 8'h0B);
    #2 rstN = 1'b1;
    runUntilDone(edges);
    checkOutput("postreset_latency", 32'(edges), 32'd577);
    checkOutput("postreset_bytes", 32'(countByte(tensorOut, 8'h39)), 32'd576);
    checkOutput("postreset_overflow", 32'(overflow), 32'd0);
    goIdle("postreset_idle_done");

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
